caravel_uart_echo: RTL and testbench

Self-contained boot-and-echo block for the Caravel user project area: models the path "boot from SPI flash, raise alive checkbits, echo UART bytes" that the Microwatt integration exercises. After reset it optionally reads a 32-bit boot word from an external SPI flash (read command 0x03), then drives checkbits to 0x0ffe and echoes every correctly framed 8N1 byte received on uart_rx back on uart_tx.

---
 rtl/caravel_uart_echo.sv | 235 +++++++++++++++++++++++
 tb/tb_caravel_uart_echo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/caravel_uart_echo.sv
// caravel_uart_echo: boot word fetch from SPI flash, alive checkbits,
// and an 8N1 UART echo through a single holding register.
module caravel_uart_echo #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        boot_flash,
   output logic        flash_csb,
   output logic        flash_clk,
   output logic        flash_io0,
   input  logic        flash_io1,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic [15:0] checkbits,
   output logic [31:0] boot_word
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
   localparam logic [31:0]   READ_CMD  = 32'h0300_0000;

   typedef enum logic [1:0] {
      BOOT_SEL,
      FLASH,
      ALIVE
   } top_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT
   } rx_t;

   top_t        top;
   logic        ph;
   logic [5:0]  fbit;
   logic [31:0] cmd_sr;
   logic [31:0] rd_sr;
   logic        alive;

   logic [1:0]    sync;
   logic          rxs;
   rx_t           rx_st;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_sr;
   logic          rx_valid;
   logic [7:0]    rx_byte;

   logic          hold_valid;
   logic [7:0]    hold_byte;
   logic          tx_busy;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_idx;
   logic [9:0]    tx_sr;

   assign alive = (top == ALIVE);
   assign rxs   = sync[1];

   // Boot sequencer: optional 64-bit SPI read, then alive forever.
   always_ff @(posedge clock) begin
      if (reset) begin
         top       <= BOOT_SEL;
         flash_csb <= 1'b1;
         flash_clk <= 1'b0;
         flash_io0 <= 1'b0;
         checkbits <= 16'h0000;
         boot_word <= 32'h0;
         ph        <= 1'b0;
         fbit      <= 6'd0;
         cmd_sr    <= 32'h0;
         rd_sr     <= 32'h0;
      end else begin
         unique case (top)
            BOOT_SEL: begin
               if (boot_flash) begin
                  top       <= FLASH;
                  flash_csb <= 1'b0;
                  flash_io0 <= READ_CMD[31];
                  cmd_sr    <= READ_CMD << 1;
                  ph        <= 1'b0;
                  fbit      <= 6'd0;
               end else begin
                  top <= ALIVE;
               end
            end
            FLASH: begin
               if (!ph) begin
                  flash_clk <= 1'b1;
                  ph        <= 1'b1;
                  if (fbit[5])
                     rd_sr <= {rd_sr[30:0], flash_io1};
               end else begin
                  flash_clk <= 1'b0;
                  ph        <= 1'b0;
                  if (fbit == 6'd63) begin
                     flash_csb <= 1'b1;
                     flash_io0 <= 1'b0;
                     boot_word <= rd_sr;
                     top       <= ALIVE;
                  end else begin
                     fbit      <= fbit + 6'd1;
                     flash_io0 <= cmd_sr[31];
                     cmd_sr    <= {cmd_sr[30:0], 1'b0};
                  end
               end
            end
            ALIVE: begin
               checkbits <= 16'h0ffe;
            end
            default: begin
               top <= BOOT_SEL;
            end
         endcase
      end
   end

   // Two-flop synchroniser for the asynchronous serial input.
   always_ff @(posedge clock) begin
      if (reset)
         sync <= 2'b11;
      else
         sync <= {sync[0], uart_rx};
   end

   // Receiver: mid-bit sampling, glitch reject, framing-error recovery.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_st    <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= 3'd0;
         rx_sr    <= 8'h00;
         rx_valid <= 1'b0;
         rx_byte  <= 8'h00;
      end else begin
         rx_valid <= 1'b0;
         unique case (rx_st)
            RX_IDLE: begin
               if (alive && !rxs) begin
                  rx_st  <= RX_START;
                  rx_cnt <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt <= '0;
                  rx_bit <= 3'd0;
                  rx_st  <= rxs ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt <= '0;
                  rx_sr  <= {rxs, rx_sr[7:1]};
                  if (rx_bit == 3'd7)
                     rx_st <= RX_STOP;
                  else
                     rx_bit <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt <= '0;
                  if (rxs) begin
                     rx_valid <= 1'b1;
                     rx_byte  <= rx_sr;
                     rx_st    <= RX_IDLE;
                  end else begin
                     rx_st <= RX_WAIT;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_WAIT: begin
               if (rxs)
                  rx_st <= RX_IDLE;
            end
            default: begin
               rx_st <= RX_IDLE;
            end
         endcase
      end
   end

   // Holding register and transmitter; holding frees when a frame starts.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_byte  <= 8'h00;
         tx_busy    <= 1'b0;
         tx_cnt     <= '0;
         tx_idx     <= 4'd0;
         tx_sr      <= 10'h3ff;
         uart_tx    <= 1'b1;
      end else begin
         if (!tx_busy && hold_valid) begin
            tx_busy    <= 1'b1;
            tx_sr      <= {1'b1, hold_byte, 1'b0};
            uart_tx    <= 1'b0;
            tx_cnt     <= '0;
            tx_idx     <= 4'd0;
            hold_valid <= 1'b0;
         end else if (tx_busy) begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt <= '0;
               if (tx_idx == 4'd9) begin
                  tx_busy <= 1'b0;
               end else begin
                  tx_idx  <= tx_idx + 4'd1;
                  uart_tx <= tx_sr[1];
                  tx_sr   <= {1'b1, tx_sr[9:1]};
               end
            end else begin
               tx_cnt <= tx_cnt + 1'b1;
            end
         end
         if (rx_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_byte  <= rx_byte;
         end
      end
   end

endmodule

// File: tb/tb_caravel_uart_echo.sv
// tb_caravel_uart_echo: flash boot, echo, framing, back-to-back,
// random bytes and mid-frame reset against a queue-based model.
module tb_caravel_uart_echo;

   localparam int CLK_FREQ = 100_000_000;
   localparam int BAUD     = 1_000_000;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int FRAME    = 10 * DIV;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        boot_flash = 1'b1;
   logic        flash_io1 = 1'b0;
   logic        uart_rx = 1'b1;
   logic        flash_csb;
   logic        flash_clk;
   logic        flash_io0;
   logic        uart_tx;
   logic [15:0] checkbits;
   logic [31:0] boot_word;

   caravel_uart_echo #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD(BAUD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .boot_flash(boot_flash),
      .flash_csb(flash_csb),
      .flash_clk(flash_clk),
      .flash_io0(flash_io0),
      .flash_io1(flash_io1),
      .uart_rx(uart_rx),
      .uart_tx(uart_tx),
      .checkbits(checkbits),
      .boot_word(boot_word)
   );

   always #5 clock = ~clock;

   int    passed = 0;
   int    total = 0;
   longint cyc = 0;

   always @(posedge clock) cyc++;

   // SPI flash model: captures command bits, returns fl_data MSB first
   int          fl_bits = 0;
   int          csb_falls = 0;
   logic [31:0] fl_cmd = 32'h0;
   logic [31:0] fl_data = 32'h0;

   always @(negedge flash_csb) begin
      fl_bits = 0;
      csb_falls++;
   end

   always @(posedge flash_clk) begin
      if (flash_csb === 1'b0) begin
         if (fl_bits < 32)
            fl_cmd = {fl_cmd[30:0], flash_io0};
         fl_bits++;
      end
   end

   always @(negedge flash_clk) begin
      if (flash_csb === 1'b0 && fl_bits >= 32 && fl_bits < 64)
         flash_io1 = fl_data[63 - fl_bits];
   end

   // UART TX monitor: records whole-frame line levels per start edge
   logic [7:0] rxq[$];
   logic       stopq[$];
   int         lowq[$];
   longint     startq[$];
   bit         mon_busy = 1'b0;
   logic       lv[FRAME];
   logic [7:0] mb;
   int         mrun;
   longint     mst;

   always begin
      @(negedge clock);
      if (reset === 1'b0 && uart_tx === 1'b0) begin
         mon_busy = 1'b1;
         mst = cyc;
         lv[0] = 1'b0;
         for (int i = 1; i < FRAME; i++) begin
            @(negedge clock);
            lv[i] = uart_tx;
         end
         for (int k = 0; k < 8; k++)
            mb[k] = lv[DIV / 2 + (k + 1) * DIV];
         mrun = 0;
         while (mrun < FRAME && lv[mrun] === 1'b0)
            mrun++;
         rxq.push_back(mb);
         stopq.push_back(lv[DIV / 2 + 9 * DIV]);
         lowq.push_back(mrun);
         startq.push_back(mst);
         mon_busy = 1'b0;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clock);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge clock);
      end
      uart_rx = stop;
      repeat (DIV) @(negedge clock);
      uart_rx = 1'b1;
   endtask

   task automatic release_and_wait(output int edges);
      longint t0;
      bit     saw;
      saw = 1'b0;
      reset = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (!saw && csb_falls > 0 && flash_csb === 1'b1) begin
            saw = 1'b1;
            chk("checkbits_at_csb_rise", 32'(checkbits), 32'h0);
         end
         if (checkbits === 16'h0ffe)
            break;
      end
      edges = int'(cyc - t0);
   endtask

   task automatic wait_frames(input string tag, input int n,
                              input int budget);
      int k;
      k = 0;
      while (rxq.size() < n && k < budget) begin
         @(negedge clock);
         k++;
      end
      chk(tag, rxq.size(), n);
   endtask

   task automatic clear_q();
      rxq.delete();
      stopq.delete();
      lowq.delete();
      startq.delete();
   endtask

   logic [7:0] expq[$];
   logic [7:0] rb;
   int         edges;
   int         gap;
   int         nexp;
   longint     rs;
   longint     lat;

   initial begin
      fl_data = 32'hDEADBEEF;
      boot_flash = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_csb", 32'(flash_csb), 32'h1);
      chk("rst_fclk", 32'(flash_clk), 32'h0);
      chk("rst_io0", 32'(flash_io0), 32'h0);
      chk("rst_tx", 32'(uart_tx), 32'h1);
      chk("rst_checkbits", 32'(checkbits), 32'h0);
      chk("rst_boot_word", boot_word, 32'h0);

      // flash boot
      csb_falls = 0;
      release_and_wait(edges);
      chk("flash_alive_edges", edges, 130);
      chk("flash_cmd", fl_cmd, 32'h0300_0000);
      chk("flash_bits", fl_bits, 64);
      chk("flash_csb_falls", csb_falls, 1);
      chk("flash_boot_word", boot_word, 32'hDEADBEEF);
      chk("flash_csb_idle", 32'(flash_csb), 32'h1);

      // skip flash
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      boot_flash = 1'b0;
      csb_falls = 0;
      release_and_wait(edges);
      chk("skip_alive_edges", edges, 2);
      chk("skip_csb_falls", csb_falls, 0);
      chk("skip_boot_word", boot_word, 32'h0);
      chk("skip_checkbits", 32'(checkbits), 32'h0ffe);

      // single echo with timing
      clear_q();
      rs = cyc;
      send_byte(8'h37, 1'b1);
      wait_frames("echo37_frames", 1, 3 * FRAME);
      if (rxq.size() >= 1) begin
         chk("echo37_byte", 32'(rxq[0]), 32'h37);
         chk("echo37_stop", 32'(stopq[0]), 32'h1);
         chk("echo37_start_len", lowq[0], DIV);
         lat = startq[0] - rs;
         chk("echo37_latency_ok",
             32'(lat >= 950 && lat <= 960), 32'h1);
      end

      // framing error then good byte
      repeat (FRAME) @(negedge clock);
      clear_q();
      send_byte(8'h55, 1'b0);
      repeat (2 * DIV) @(negedge clock);
      send_byte(8'hA3, 1'b1);
      wait_frames("frame_err_frames", 1, 3 * FRAME);
      repeat (2 * FRAME) @(negedge clock);
      chk("frame_err_count", rxq.size(), 1);
      if (rxq.size() >= 1)
         chk("frame_err_byte", 32'(rxq[0]), 32'hA3);

      // three back-to-back bytes
      clear_q();
      send_byte(8'h31, 1'b1);
      send_byte(8'h32, 1'b1);
      send_byte(8'h33, 1'b1);
      wait_frames("b2b_frames", 3, 4 * FRAME);
      for (int i = 0; i < rxq.size() && i < 3; i++)
         chk($sformatf("b2b_byte%0d", i), 32'(rxq[i]), 32'(8'h31 + i));

      // randomized bytes and gaps, all must echo in order
      repeat (2 * FRAME) @(negedge clock);
      clear_q();
      expq.delete();
      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom);
         gap = $urandom_range(0, 2 * DIV);
         expq.push_back(rb);
         send_byte(rb, 1'b1);
         repeat (gap) @(negedge clock);
      end
      nexp = expq.size();
      wait_frames("rand_frames", nexp, 4 * FRAME);
      for (int i = 0; i < nexp && i < rxq.size(); i++) begin
         chk($sformatf("rand_byte%0d", i), 32'(rxq[i]), 32'(expq[i]));
         chk($sformatf("rand_stop%0d", i), 32'(stopq[i]), 32'h1);
      end

      // reset mid-frame
      repeat (2 * FRAME) @(negedge clock);
      clear_q();
      send_byte(8'h5A, 1'b1);
      for (int i = 0; i < 2 * DIV && !mon_busy; i++)
         @(negedge clock);
      chk("mid_tx_started", 32'(mon_busy), 32'h1);
      repeat (3 * DIV) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_tx", 32'(uart_tx), 32'h1);
      chk("mid_rst_checkbits", 32'(checkbits), 32'h0);
      chk("mid_rst_csb", 32'(flash_csb), 32'h1);
      boot_flash = 1'b1;
      fl_data = $urandom;
      csb_falls = 0;
      for (int i = 0; i < 2 * FRAME && mon_busy; i++)
         @(negedge clock);
      clear_q();
      release_and_wait(edges);
      chk("reboot_edges", edges, 130);
      chk("reboot_csb_falls", csb_falls, 1);
      chk("reboot_boot_word", boot_word, fl_data);
      chk("reboot_no_tx", rxq.size(), 0);

      send_byte(8'hC6, 1'b1);
      wait_frames("reboot_frames", 1, 3 * FRAME);
      if (rxq.size() >= 1)
         chk("reboot_echo", 32'(rxq[0]), 32'hC6);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
